// File: rtl/nand_unit_pkg.sv
// Shared types and constants for the nand_unit logic slice.
package nand_unit_pkg;

    typedef enum logic [1:0] {
        OP_NAND = 2'b00,
        OP_AND  = 2'b01,
        OP_NOTA = 2'b10,
        OP_NOTB = 2'b11
    } op_e;

    localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/nand_slice.sv
// Combinational WIDTH-bit slice built from per-bit and_gate/not_gate cells;
// exposes NAND, AND and the two single-operand inversions.
module and_gate (
    input  logic a,
    input  logic b,
    output logic r
);
    assign r = a & b;
endmodule

module not_gate (
    input  logic a,
    output logic r
);
    assign r = ~a;
endmodule

module nand_slice
    import nand_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] nand_r,
    output logic [WIDTH-1:0] and_r,
    output logic [WIDTH-1:0] nota_r,
    output logic [WIDTH-1:0] notb_r
);

    logic [WIDTH-1:0] w_and;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and_gate u_and (.a(a[i]),     .b(b[i]), .r(w_and[i]));
        not_gate u_nand(.a(w_and[i]),           .r(nand_r[i]));
        not_gate u_nota(.a(a[i]),               .r(nota_r[i]));
        not_gate u_notb(.a(b[i]),               .r(notb_r[i]));
    end

    assign and_r = w_and;

endmodule

// File: rtl/nand_unit.sv
// Registered bitwise logic unit (NAND/AND/NOTA/NOTB), one-cycle latency.
// Optional registered parity output enabled by NAND_UNIT_PARITY_EN.
module nand_unit
    import nand_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
`ifdef NAND_UNIT_PARITY_EN
    output logic             r_parity,
`endif
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] w_nand;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_nota;
    logic [WIDTH-1:0] w_notb;
    logic [WIDTH-1:0] w_sel;

    logic [WIDTH-1:0] r_result;
    logic             r_valid;

    nand_slice #(.WIDTH(WIDTH)) u_slice (
        .a      (a),
        .b      (b),
        .nand_r (w_nand),
        .and_r  (w_and),
        .nota_r (w_nota),
        .notb_r (w_notb)
    );

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves w_sel unassigned (no latch).
        w_sel = w_nand;
        case (op_e'(op))
            OP_NAND: w_sel = w_nand;
            OP_AND:  w_sel = w_and;
            OP_NOTA: w_sel = w_nota;
            OP_NOTB: w_sel = w_notb;
            default: w_sel = w_nand;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) r_result <= w_sel;
        end
    end

`ifdef NAND_UNIT_PARITY_EN
    logic r_par;

    // Parity tracks the value r_result is about to take, so it stays aligned with r.
    always_ff @(posedge clk) begin
        if (rst)           r_par <= 1'b0;
        else if (in_valid) r_par <= ^w_sel;
    end

    assign r_parity = r_par;
`endif

    assign r         = r_result;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_nand_unit.sv
// Self-checking bench for nand_unit: WIDTH=8 and WIDTH=1 instances against a truth-table model.
// Build with NAND_UNIT_PARITY_EN defined to also check r_parity.
module tb_nand_unit;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v8, v1;
    logic [1:0] op8, op1;
    logic [7:0] a8, b8;
    logic       a1, b1;

    logic [7:0] r8;
    logic       ov8;
    logic [0:0] r1;
    logic       ov1;
`ifdef NAND_UNIT_PARITY_EN
    logic       p8, p1;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [7:0] m_r8;
    logic       m_v8;
    logic       m_p8;
    logic       m_r1;
    logic       m_v1;
    logic       m_p1;

    nand_unit #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .op        (op8),
        .a         (a8),
        .b         (b8),
        .out_valid (ov8),
`ifdef NAND_UNIT_PARITY_EN
        .r_parity  (p8),
`endif
        .r         (r8)
    );

    nand_unit #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .op        (op1),
        .a         (a1),
        .b         (b1),
        .out_valid (ov1),
`ifdef NAND_UNIT_PARITY_EN
        .r_parity  (p1),
`endif
        .r         (r1)
    );

    // Per-bit truth tables indexed by {a_bit, b_bit}.
    function automatic logic [7:0] ref_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [3:0] tt;
        logic [7:0] res;
        case (op)
            2'b00:   tt = 4'b0111;
            2'b01:   tt = 4'b1000;
            2'b10:   tt = 4'b0011;
            default: tt = 4'b0101;
        endcase
        for (int i = 0; i < 8; i++) res[i] = tt[{a[i], b[i]}];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [7:0] t;
        @(posedge clk);
        if (rst) begin
            m_r8 = '0; m_v8 = 1'b0; m_p8 = 1'b0;
            m_r1 = 1'b0; m_v1 = 1'b0; m_p1 = 1'b0;
        end else begin
            m_v8 = v8;
            if (v8) begin
                m_r8 = ref_fn(op8, a8, b8);
                m_p8 = ^m_r8;
            end
            m_v1 = v1;
            if (v1) begin
                t    = ref_fn(op1, {7'b0, a1}, {7'b0, b1});
                m_r1 = t[0];
                m_p1 = t[0];
            end
        end
        #1;
        chk("r8_model", r8, m_r8);
        chk("ov8_model", {7'b0, ov8}, {7'b0, m_v8});
        chk("r1_model", {7'b0, r1}, {7'b0, m_r1});
        chk("ov1_model", {7'b0, ov1}, {7'b0, m_v1});
`ifdef NAND_UNIT_PARITY_EN
        chk("p8_model", {7'b0, p8}, {7'b0, m_p8});
        chk("p1_model", {7'b0, p1}, {7'b0, m_p1});
`endif
    endtask

    logic [1:0] tt_in  [4];
    logic       tt_exp [4];
    logic [1:0] op_seq [4];
    logic [7:0] op_exp [4];

    initial begin
        tt_in  = '{2'b00, 2'b01, 2'b10, 2'b11};
        tt_exp = '{1'b1, 1'b1, 1'b1, 1'b0};
        op_seq = '{2'b01, 2'b10, 2'b11, 2'b00};
        op_exp = '{8'hC0, 8'h0F, 8'h33, 8'h3F};

        // Reset held 2 cycles with a valid input present
        rst = 1'b1; v8 = 1'b1; v1 = 1'b1; op8 = 2'b00; op1 = 2'b00;
        a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("reset_r8", r8, 8'h00);
            chk("reset_ov8", {7'b0, ov8}, 8'h00);
            chk("reset_r1", {7'b0, r1}, 8'h00);
        end
        rst = 1'b0; v8 = 1'b0; v1 = 1'b0;
        step();
        chk("post_reset_ov8", {7'b0, ov8}, 8'h00);
        chk("post_reset_ov1", {7'b0, ov1}, 8'h00);

        // NAND truth table on WIDTH=1, back-to-back
        v1 = 1'b1; op1 = 2'b00;
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = tt_in[i];
            step();
            chk("nand_tt_r", {7'b0, r1}, {7'b0, tt_exp[i]});
            chk("nand_tt_ov", {7'b0, ov1}, 8'h01);
        end
        v1 = 1'b0;

        // Each op on WIDTH=8
        v8 = 1'b1; a8 = 8'hF0; b8 = 8'hCC;
        for (int i = 0; i < 4; i++) begin
            op8 = op_seq[i];
            step();
            chk("op_r8", r8, op_exp[i]);
            chk("op_ov8", {7'b0, ov8}, 8'h01);
        end
`ifdef NAND_UNIT_PARITY_EN
        chk("parity_3f", {7'b0, p8}, 8'h00);
`endif

        // Hold while in_valid low and operands change
        v8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom);
            step();
            chk("hold_r8", r8, 8'h3F);
            chk("hold_ov8", {7'b0, ov8}, 8'h00);
        end

`ifdef NAND_UNIT_PARITY_EN
        v8 = 1'b1; op8 = 2'b10; a8 = 8'hF0;
        step();
        chk("parity_0f_r", r8, 8'h0F);
        chk("parity_0f", {7'b0, p8}, 8'h00);
        a8 = 8'hF8;
        step();
        chk("parity_07_r", r8, 8'h07);
        chk("parity_07", {7'b0, p8}, 8'h01);
`endif

        // Reset mid-stream discards the result and leaves nothing stale
        v8 = 1'b1; op8 = 2'b00; a8 = 8'hFF; b8 = 8'hFF;
        step();
        chk("mid_pre_r8", r8, 8'h00);
        chk("mid_pre_ov8", {7'b0, ov8}, 8'h01);
        rst = 1'b1; a8 = 8'h00;
        step();
        chk("mid_rst_r8", r8, 8'h00);
        chk("mid_rst_ov8", {7'b0, ov8}, 8'h00);
        rst = 1'b0; v8 = 1'b0;
        step();
        chk("mid_after_ov8", {7'b0, ov8}, 8'h00);
        chk("mid_after_r8", r8, 8'h00);

        // Randomised traffic on both instances with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 24) == 0);
            v8  = 1'($urandom); v1 = 1'($urandom);
            op8 = 2'($urandom); op1 = 2'($urandom);
            a8  = 8'($urandom); b8 = 8'($urandom);
            a1  = 1'($urandom); b1 = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
